uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver paired with `uart_tx` in the TCORE UART peripheral. It synchronizes the incoming `rx_bit_i` line and detects a start bit. It samples 8 data bits LSB-first plus one stop bit at mid-bit, using the same `baud_div_i` bit-period convention as the transmitter. Received bytes go into a 32-entry FIFO that the bus-side register logic reads.

## Interface
- `DEPTH`, 32: FIFO entries; must be a power of two.
- `clk_i`, in, 1: core clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `baud_div_i`, in, 16: clock cycles per bit. Legal values are ≥4; smaller values are unsupported.
- `rx_en_i`, in, 1: receiver enable.
- `rx_bit_i`, in, 1: serial input. Asynchronous to `clk_i`; idles high.
- `rx_re_i`, in, 1: FIFO pop strobe.
- `err_clr_i`, in, 1: clears the sticky error flags.
- `dout_o`, out, 8: FIFO head byte (show-ahead).
- `full_o`, out, 1: FIFO full.
- `empty_o`, out, 1: FIFO empty.
- `frame_err_o`, out, 1: sticky flag; a stop bit was sampled low.
- `overrun_o`, out, 1: sticky flag; a byte was dropped because the FIFO was full.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `rx_bit_i`, reset value 1. The output is `rx_s`. All decisions use `rx_s`.
- **Counter:** `baud_cnt` is 16 bits and is cleared on every state change. Bit counter `bit_cnt` is 3 bits.
- **FSM states:**
  - IDLE: if `rx_en_i` and `rx_s==0`, go to START.
  - START: wait until `baud_cnt == (baud_div_i>>1)-1`. Then, if `rx_s==0`, go to DATA. Otherwise it was a glitch: go to IDLE with no flag.
  - DATA: at `baud_cnt == baud_div_i-1`, sample. Shift right into `shreg` with the new bit at [7]. After the 8th bit (`bit_cnt==7`), go to STOP; otherwise increment `bit_cnt`.
  - STOP: at `baud_cnt == baud_div_i-1`, sample, then go to IDLE in the same cycle.
    - Sample = 1 and `!full_o`: push `shreg`.
    - Sample = 1 and `full_o`: drop the byte and set `overrun_o`.
    - Sample = 0: drop the byte and set `frame_err_o`.
- Returning to IDLE at mid-stop-bit gives half a bit of margin to catch the next start edge.
- **Disable:** `rx_en_i` low forces IDLE and clears `baud_cnt` and `bit_cnt`. FIFO contents and flags are retained.
- **FIFO:**
  - Pointers are `$clog2(DEPTH)+1` bits with a wrap bit.
  - `full_o`: MSBs differ and the low bits are equal.
  - `empty_o`: pointers are equal.
  - Pop on `rx_re_i & !empty_o`; a pop while empty is ignored.
  - A push and a pop in the same cycle are both performed.
  - The push decision uses `full_o` before the pop, so a push while full is dropped even if a pop occurs in the same cycle.
- **Flags:**
  - `err_clr_i` clears both flags.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- **Reset values:** `empty_o`=1, `full_o`=0, `frame_err_o`=0, `overrun_o`=0. `dout_o` is 0 because the FIFO storage is cleared. FSM is in IDLE; counters are 0.
- **Input latency:** the synchronizer adds 2 cycles.
- **Byte latency:** with `baud_div_i`=D, the push occurs (D/2) + 9·D cycles after `rx_s` falls. `empty_o` deasserts on the following cycle.
- **Read path:** `dout_o` is combinational from the FIFO head. It updates one cycle after a pop.
- **Reset mid-frame:** the partial byte is lost; no flags are set.
- Changing `baud_div_i` mid-frame is undefined behaviour.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each data and stop sample is the 2-of-3 majority of `rx_s` at `baud_cnt` = `target-2`, `target-1` and `target`. The start check stays a single sample.
- Not defined: a single sample of `rx_s` at `target`.

## Structure
- `tcore_param`:
  - FSM enum `uart_rx_state_e` {IDLE, START, DATA, STOP}.
  - `UART_FIFO_DEPTH` = 32.
- Sub-module `uart_fifo`: parameterized synchronous FIFO with push/pop, show-ahead output, and full/empty flags. It is instantiated here and is reusable by `uart_tx`.
- Synchronizer and FSM stay inline.

## Test plan
- **Single byte:** D=16; drive 0xA5 as a clean frame → push 152 cycles after `rx_s` falls; `dout_o`=0xA5; pulsing `rx_re_i` → `empty_o`=1.
- **Back-to-back:** D=16; drive 0x00, 0xFF, 0x55 back-to-back with no idle gap → all three bytes read in order; no flags set.
- **Glitch:** D=16; low pulse of 4 cycles on `rx_bit_i` → FSM returns to IDLE; FIFO remains empty; no flags set.
- **Framing error:** stop bit driven 0 on byte 0x3C → `frame_err_o`=1; FIFO remains empty; `err_clr_i` → 0.
- **Overrun:** 33 frames with no reads → `full_o`=1 after the 32nd; `overrun_o`=1; the first 32 bytes are read back intact.
- **Async reset / majority:** assert `rst_ni` mid-DATA → all outputs return to reset values immediately. With `UART_RX_MAJORITY_EN`, a 1-cycle inverted glitch at the sample point → byte still correct.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared TCORE UART definitions: receiver FSM encoding, default FIFO depth and
// a 2-of-3 majority helper used by the oversampling receive option.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous show-ahead FIFO shared by the UART receive and transmit paths.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. Storage is reset so the head reads 0
// out of reset.
//
// Ports:
//   clk_i    core clock
//   rst_ni   asynchronous active-low reset
//   push_i   write din_i (ignored while full)
//   din_i    write data
//   pop_i    advance the head (ignored while empty)
//   dout_o   head entry, combinational
//   full_o   all DEPTH entries occupied
//   empty_o  no entries occupied
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Both gates use the flags from before this cycle's update, so a push
    // while full is dropped even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din_i;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// TCORE UART serial receiver. Synchronizes rx_bit_i, detects a start bit,
// checks it at mid-bit, samples 8 data bits LSB-first and one stop bit at
// mid-bit, and pushes good bytes into a show-ahead FIFO.
//
// Build option: UART_RX_MAJORITY_EN -- when defined, each data/stop sample is
// the 2-of-3 majority of rx_s at target-2, target-1 and target. The start
// check remains a single sample. When undefined, one sample at target.
//
// FSM:
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low while enabled
//   START | timing half a bit to re-check the start bit
//   DATA  | sampling 8 data bits, one per baud_div_i cycles
//   STOP  | sampling stop bit; push, drop on overrun, or flag framing error
//
// Ports:
//   clk_i        core clock
//   rst_ni       asynchronous active-low reset
//   baud_div_i   clock cycles per bit (>= 4)
//   rx_en_i      receiver enable; low forces IDLE
//   rx_bit_i     asynchronous serial input, idles high
//   rx_re_i      FIFO pop strobe
//   err_clr_i    clears frame_err_o and overrun_o
//   dout_o       FIFO head byte
//   full_o       FIFO full
//   empty_o      FIFO empty
//   frame_err_o  sticky: stop bit sampled low
//   overrun_o    sticky: byte dropped because FIFO full
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] baud_div_i,
    input  logic        rx_en_i,
    input  logic        rx_bit_i,
    input  logic        rx_re_i,
    input  logic        err_clr_i,
    output logic [7:0]  dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    logic           rx_meta_q;
    logic           rx_s_q;
    uart_rx_state_e state_q, state_d;
    logic [15:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
    logic           push;
    logic           frame_set;
    logic           overrun_set;
    logic           sample_bit;
    logic [15:0]    half_tgt;
    logic [15:0]    bit_tgt;

    assign half_tgt = (baud_div_i >> 1) - 16'd1;
    assign bit_tgt  = baud_div_i - 16'd1;

    // Two-stage synchronizer; resets to the idle (high) line level so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_bit_i;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // maj_q[0] holds rx_s at target-2, maj_q[1] at target-1; the third vote
    // is the live rx_s at target. With baud_div_i >= 4 both early points
    // fall inside the same bit period after the counter wrap.
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (baud_cnt_q == bit_tgt - 16'd2) begin
            maj_d[0] = rx_s_q;
        end
        if (baud_cnt_q == bit_tgt - 16'd1) begin
            maj_d[1] = rx_s_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end

    assign sample_bit = maj3(maj_q[0], maj_q[1], rx_s_q);
`else
    assign sample_bit = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_cnt_q == half_tgt) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == bit_tgt) begin
                    baud_cnt_d = '0;
                    shreg_d    = {sample_bit, shreg_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch the
                // next start edge of a back-to-back frame.
                if (baud_cnt_q == bit_tgt) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (!sample_bit) begin
                        frame_set = 1'b1;
                    end else if (full_o) begin
                        overrun_set = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase

        if (!rx_en_i) begin
            state_d     = IDLE;
            baud_cnt_d  = '0;
            bit_cnt_d   = '0;
            push        = 1'b0;
            frame_set   = 1'b0;
            overrun_set = 1'b0;
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        frame_err_d = err_clr_i ? 1'b0 : frame_err_q;
        overrun_d   = err_clr_i ? 1'b0 : overrun_q;
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (shreg_q),
        .pop_i   (rx_re_i),
        .dout_o  (dout_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at baud_div_i = 16. Frames are driven one clock
// per step from the falling clock edge; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] baud_div_i = 16'd16;
    logic        rx_en_i = 1'b0;
    logic        rx_bit_i = 1'b1;
    logic        rx_re_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic [7:0]  dout_o;
    logic        full_o;
    logic        empty_o;
    logic        frame_err_o;
    logic        overrun_o;

    int n_checks = 0;
    int n_errors = 0;
    int push_cyc;

    always #5 clk_i = ~clk_i;

    uart_rx dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .baud_div_i  (baud_div_i),
        .rx_en_i     (rx_en_i),
        .rx_bit_i    (rx_bit_i),
        .rx_re_i     (rx_re_i),
        .err_clr_i   (err_clr_i),
        .dout_o      (dout_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drives start, 8 data bits LSB-first and the stop bit, 16 clocks each.
    // glitch_c (>= 0) inverts the line for that single step. push_cyc
    // records the first step after which empty_o was seen low.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_c);
        logic [9:0] fr;
        logic       was_empty;
        fr        = {stop, b, 1'b0};
        was_empty = empty_o;
        push_cyc  = -1;
        for (int c = 0; c < 160; c++) begin
            rx_bit_i = fr[c / 16] ^ (c == glitch_c);
            @(negedge clk_i);
            if (push_cyc < 0 && was_empty && !empty_o) begin
                push_cyc = c + 1;
            end
        end
        rx_bit_i = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_eq(tag, 32'(dout_o), 32'(exp));
        rx_re_i = 1'b1;
        @(negedge clk_i);
        rx_re_i = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(3);
        check_eq("rst_empty", 32'(empty_o), 32'd1);
        check_eq("rst_full", 32'(full_o), 32'd0);
        check_eq("rst_ferr", 32'(frame_err_o), 32'd0);
        check_eq("rst_ovr", 32'(overrun_o), 32'd0);
        check_eq("rst_dout", 32'(dout_o), 32'd0);
        rst_ni  = 1'b1;
        rx_en_i = 1'b1;
        idle(4);

        // Single byte with latency: rx_s falls 2 clocks after the drive,
        // push strobe 152 cycles later, empty_o low one cycle after that.
        send_frame(8'hA5, 1'b1, -1);
        check_eq("single_latency", 32'(push_cyc), 32'd155);
        check_eq("single_dout", 32'(dout_o), 32'hA5);
        pop_check("single_pop", 8'hA5);
        check_eq("single_empty", 32'(empty_o), 32'd1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        idle(4);
        pop_check("b2b_0", 8'h00);
        pop_check("b2b_1", 8'hFF);
        pop_check("b2b_2", 8'h55);
        check_eq("b2b_empty", 32'(empty_o), 32'd1);
        check_eq("b2b_ferr", 32'(frame_err_o), 32'd0);
        check_eq("b2b_ovr", 32'(overrun_o), 32'd0);

        // Glitch shorter than half a bit is rejected
        rx_bit_i = 1'b0;
        idle(4);
        rx_bit_i = 1'b1;
        idle(40);
        check_eq("glitch_empty", 32'(empty_o), 32'd1);
        check_eq("glitch_ferr", 32'(frame_err_o), 32'd0);
        check_eq("glitch_ovr", 32'(overrun_o), 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        idle(4);
        pop_check("glitch_recover", 8'h5A);

        // Disabled receiver ignores the line
        rx_en_i = 1'b0;
        send_frame(8'h42, 1'b1, -1);
        idle(4);
        check_eq("disable_empty", 32'(empty_o), 32'd1);
        rx_en_i = 1'b1;
        idle(4);

        // Framing error
        send_frame(8'h3C, 1'b0, -1);
        idle(32);
        check_eq("ferr_set", 32'(frame_err_o), 32'd1);
        check_eq("ferr_empty", 32'(empty_o), 32'd1);
        check_eq("ferr_ovr", 32'(overrun_o), 32'd0);
        clear_errs();
        check_eq("ferr_clr", 32'(frame_err_o), 32'd0);

        // Overrun: 33 frames, no reads
        for (int i = 0; i < 33; i++) begin
            send_frame(8'(i * 7 + 3), 1'b1, -1);
            if (i == 31) begin
                check_eq("ovr_full32", 32'(full_o), 32'd1);
                check_eq("ovr_flag32", 32'(overrun_o), 32'd0);
            end
        end
        idle(4);
        check_eq("ovr_flag", 32'(overrun_o), 32'd1);
        check_eq("ovr_full", 32'(full_o), 32'd1);
        check_eq("ovr_ferr", 32'(frame_err_o), 32'd0);
        for (int i = 0; i < 32; i++) begin
            pop_check($sformatf("ovr_rd%0d", i), 8'(i * 7 + 3));
        end
        check_eq("ovr_empty", 32'(empty_o), 32'd1);
        clear_errs();
        check_eq("ovr_clr", 32'(overrun_o), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inverted glitch exactly at the sample point is outvoted.
        send_frame(8'hC3, 1'b1, 16 * 3 + 8);
        send_frame(8'h96, 1'b1, 16 * 9 + 8);
        idle(4);
        pop_check("maj_data", 8'hC3);
        pop_check("maj_stop", 8'h96);
        check_eq("maj_ferr", 32'(frame_err_o), 32'd0);
`endif

        // Async reset mid-DATA with a byte held and a flag set
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h3C, 1'b0, -1);
        idle(32);
        check_eq("prerst_empty", 32'(empty_o), 32'd0);
        check_eq("prerst_ferr", 32'(frame_err_o), 32'd1);
        fork
            send_frame(8'h77, 1'b1, -1);
            begin
                idle(60);
                #2 rst_ni = 1'b0;
                #1;
                check_eq("arst_empty", 32'(empty_o), 32'd1);
                check_eq("arst_full", 32'(full_o), 32'd0);
                check_eq("arst_ferr", 32'(frame_err_o), 32'd0);
                check_eq("arst_ovr", 32'(overrun_o), 32'd0);
                check_eq("arst_dout", 32'(dout_o), 32'd0);
            end
        join
        rx_bit_i = 1'b1;
        idle(4);
        rst_ni = 1'b1;
        idle(40);
        check_eq("postrst_empty", 32'(empty_o), 32'd1);
        check_eq("postrst_ferr", 32'(frame_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
